// File: rtl/ifetch_pkg.sv
// Shared types for the instruction fetch stage: FSM states, the
// prefetch entry bundle (pc + word) and the instruction word size.
package ifetch_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } ifetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } fetch_entry_t;

    localparam int unsigned WORD_BYTES = 4;

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction memory request/response bus.
// master = fetch stage (req, addr out; gnt, rvalid, rdata in), slave = memory.
interface instr_fetch_if;

    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (
        output req,
        output addr,
        input  gnt,
        input  rvalid,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output gnt,
        output rvalid,
        output rdata
    );

endinterface

// File: rtl/ifetch_fifo.sv
// Prefetch FIFO of fetch_entry_t, FIFO_DEPTH entries (power of 2).
// Ports: push/data write the tail, pop removes the head, flush empties,
// head is the oldest entry, count the occupancy. Async active-low reset.
module ifetch_fifo
    import ifetch_pkg::*;
#(
    parameter  int unsigned FIFO_DEPTH = 4,
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  fetch_entry_t data,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t head,
    output logic [CW-1:0] count
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);

    fetch_entry_t  mem [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    assign do_pop  = pop && (count != '0);
    // a full FIFO still accepts a write when the head leaves the same cycle
    assign do_push = push && ((count != CW'(FIFO_DEPTH)) || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush)
            mem[wr_ptr] <= data;
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, imem requests, prefetch FIFO, branch redirect.
// Ports: clk, rst_n, imem (instr_fetch_if.master), waiting, instr,
// instr_valid, instr_pc, redirect, redirect_pc; stall_cnt when
// IFETCH_STALL_CNT_EN is defined (counts starved cycles, saturating).
module instr_fetch
    import ifetch_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst_n,
    instr_fetch_if.master imem,
    input  logic          waiting,
    output logic [31:0]   instr,
    output logic          instr_valid,
    output logic [31:0]   instr_pc,
    input  logic          redirect,
    input  logic [31:0]   redirect_pc
`ifdef IFETCH_STALL_CNT_EN
    ,
    output logic [31:0]   stall_cnt
`endif
);

    localparam int unsigned CW  = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned CW1 = CW + 1;
    localparam logic [31:0] PC0 = {RESET_PC[31:2], 2'b00};
    localparam logic [CW:0] CAP = CW1'(FIFO_DEPTH);

    ifetch_state_t state;
    ifetch_state_t state_nxt;
    logic [31:0]   pc;
    logic [31:0]   resp_pc;
    logic [31:0]   target;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] out_nxt;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] drop_nxt;
    logic [CW-1:0] count;
    logic [CW:0]   inflight;
    logic          issue;
    logic          rv;
    logic          push;
    logic          pop;
    fetch_entry_t  head;
    fetch_entry_t  din;

    assign target    = {redirect_pc[31:2], 2'b00};
    assign inflight  = {1'b0, count} + {1'b0, outstanding};
    assign imem.req  = (state == S_RUN) && (inflight < CAP);
    assign imem.addr = pc;
    assign issue     = imem.req && imem.gnt;
    // a response with nothing outstanding is a protocol error and ignored
    assign rv        = imem.rvalid && (outstanding != '0);
    assign out_nxt   = outstanding + CW'(issue) - CW'(rv);
    assign push      = rv && (state == S_RUN) && !redirect;
    assign pop       = instr_valid && waiting && !redirect;

    assign instr_valid = (count != '0);
    assign instr       = instr_valid ? head.word : '0;
    assign instr_pc    = instr_valid ? head.pc : '0;
    assign din         = '{pc: resp_pc, word: imem.rdata};

    ifetch_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst_n(rst_n),
        .push (push),
        .data (din),
        .pop  (pop),
        .flush(redirect),
        .head (head),
        .count(count)
    );

    // In S_DRAIN nothing issues, so outstanding-after-edge equals the
    // remaining drops; a redirect there reloads pc but adds no drops.
    always_comb begin
        state_nxt = state;
        drop_nxt  = drop_cnt;
        unique case (state)
            S_IDLE: begin
                state_nxt = S_RUN;
            end
            S_RUN: begin
                if (redirect && (out_nxt != '0)) begin
                    state_nxt = S_DRAIN;
                    drop_nxt  = out_nxt;
                end
            end
            S_DRAIN: begin
                if (rv)
                    drop_nxt = drop_cnt - CW'(1);
                if (drop_nxt == '0)
                    state_nxt = S_RUN;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // resp_pc is the address of the next response that will be kept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            pc          <= PC0;
            resp_pc     <= PC0;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            state       <= state_nxt;
            outstanding <= out_nxt;
            drop_cnt    <= drop_nxt;
            if (redirect) begin
                pc      <= target;
                resp_pc <= target;
            end else begin
                if (issue)
                    pc <= pc + 32'(WORD_BYTES);
                if (push)
                    resp_pc <= resp_pc + 32'(WORD_BYTES);
            end
        end
    end

`ifdef IFETCH_STALL_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt <= '0;
        else if (waiting && !instr_valid && !redirect && (stall_cnt != '1))
            stall_cnt <= stall_cnt + 32'd1;
    end
`endif

    a_rvalid_expected: assert property (
        @(posedge clk) disable iff (!rst_n)
        imem.rvalid |-> (outstanding != '0)
    );

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: memory model, in-order stream
// scoreboard, directed redirect/reset/wrap sequences and random traffic.
`timescale 1ns/1ps
module tb_instr_fetch;
    import ifetch_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        waiting;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] instr_pc;
    logic        waiting2;
    logic        redirect2;
    logic [31:0] redirect_pc2;
    logic [31:0] instr2;
    logic        instr_valid2;
    logic [31:0] instr_pc2;
`ifdef IFETCH_STALL_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] stall_cnt2;
`endif

    instr_fetch_if imem ();
    instr_fetch_if imem2 ();

    always #5 clk = ~clk;

    instr_fetch #(
        .FIFO_DEPTH(DEPTH),
        .RESET_PC  (32'h0000_0000)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem       (imem),
        .waiting    (waiting),
        .instr      (instr),
        .instr_valid(instr_valid),
        .instr_pc   (instr_pc),
        .redirect   (redirect),
        .redirect_pc(redirect_pc)
`ifdef IFETCH_STALL_CNT_EN
        ,
        .stall_cnt  (stall_cnt)
`endif
    );

    instr_fetch #(
        .FIFO_DEPTH(DEPTH),
        .RESET_PC  (32'hFFFF_FFF8)
    ) u_dut2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem       (imem2),
        .waiting    (waiting2),
        .instr      (instr2),
        .instr_valid(instr_valid2),
        .instr_pc   (instr_pc2),
        .redirect   (redirect2),
        .redirect_pc(redirect_pc2)
`ifdef IFETCH_STALL_CNT_EN
        ,
        .stall_cnt  (stall_cnt2)
`endif
    );

    int total = 0;
    int bad = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] word_of(logic [31:0] a);
        return a ^ 32'hC0DE_5A5A;
    endfunction

    // ---------------- memory model ----------------
    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    req_t        mq[$];
    int          cyc = 0;
    int          last_due = 0;
    int          issue_cnt = 0;
    int          fixed_lat = 2;
    bit          rand_gnt = 0;
    bit          rand_lat = 0;
    bit          no_gnt = 0;
    bit          stall_prev = 0;
    logic [31:0] stall_addr;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        int d;
        if (!rst_n) begin
            mq.delete();
            imem.gnt    = 1'b0;
            imem.rvalid = 1'b0;
            imem.rdata  = '0;
            last_due    = 0;
            stall_prev  = 0;
        end else begin
            if (stall_prev && !redirect && imem.req)
                chk("addr_hold", imem.addr, stall_addr);
            if (no_gnt)
                imem.gnt = 1'b0;
            else if (rand_gnt)
                imem.gnt = ($urandom_range(3) != 0);
            else
                imem.gnt = 1'b1;
            if (imem.req && imem.gnt) begin
                d = cyc + 1 + (rand_lat ? int'($urandom_range(3, 1)) : fixed_lat);
                if (d <= last_due)
                    d = last_due + 1;
                last_due = d;
                mq.push_back('{addr: imem.addr, due: d});
                issue_cnt++;
            end
            stall_prev = imem.req && !imem.gnt;
            stall_addr = imem.addr;
            chk("inflight_cap", 32'(mq.size() <= DEPTH), 1);
            imem.rvalid = 1'b0;
            imem.rdata  = '0;
            if (mq.size() > 0 && mq[0].due <= cyc + 1) begin
                imem.rvalid = 1'b1;
                imem.rdata  = word_of(mq[0].addr);
                void'(mq.pop_front());
            end
        end
    end

    // wrap check on the second instance: gnt always, no responses
    logic [31:0] a2 [3];
    int          n2 = 0;

    always @(negedge clk) begin
        if (rst_n && imem2.req && n2 < 3) begin
            a2[n2] = imem2.addr;
            n2++;
        end
    end

    // ---------------- stream scoreboard ----------------
    logic [31:0] exp_pc = '0;
    int          pops = 0;

    task automatic apply(bit w, bit r, logic [31:0] rpc);
        waiting     = w;
        redirect    = r;
        redirect_pc = rpc;
        if (!instr_valid) begin
            chk("empty_instr", instr, 0);
            chk("empty_pc", instr_pc, 0);
        end
        if (instr_valid && w && !r) begin
            chk("pop_pc", instr_pc, exp_pc);
            chk("pop_word", instr, word_of(exp_pc));
            exp_pc = exp_pc + 32'd4;
            pops++;
        end
        if (r)
            exp_pc = rpc & ~32'h3;
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic step(bit w);
        tick();
        apply(w, 1'b0, '0);
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        waiting     = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        repeat (2) @(negedge clk);
        #1;
        rst_n  = 1'b1;
        exp_pc = '0;
        pops   = 0;
    endtask

    task automatic do_redir(bit w, logic [31:0] tgt, int want_fly);
        int fly;
        int n;
        tick();
        for (n = 0; n < 10 && !imem.rvalid; n++) begin
            apply(w, 1'b0, '0);
            tick();
        end
        chk("redir_rvalid", 32'(imem.rvalid), 1);
        chk("redir_valid", 32'(instr_valid), 1);
        apply(w, 1'b1, tgt);
        fly = mq.size();
        if (want_fly >= 0)
            chk("redir_inflight", fly, want_fly);
        tick();
        chk("redir_flushed", 32'(instr_valid), 0);
        chk("redir_drop_cnt", 32'(u_dut.drop_cnt), fly);
        chk("redir_state", 32'(u_dut.state), 32'(fly != 0 ? S_DRAIN : S_RUN));
        apply(1'b1, 1'b0, '0);
        for (n = 0; n < 20 && !imem.req; n++)
            step(1'b1);
        chk("refetch_addr", imem.addr, tgt & ~32'h3);
        for (n = 0; n < 30; n++) begin
            tick();
            if (instr_valid)
                break;
            apply(1'b1, 1'b0, '0);
        end
        chk("first_pc", instr_pc, tgt & ~32'h3);
        chk("first_word", instr, word_of(tgt & ~32'h3));
        apply(1'b1, 1'b0, '0);
    endtask

    typedef struct {
        bit          w;
        bit          exp_req;
        bit          exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t tv[8];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1);
    end

    initial begin
        bit seen_req;
        waiting2     = 1'b0;
        redirect2    = 1'b0;
        redirect_pc2 = '0;
        imem2.gnt    = 1'b1;
        imem2.rvalid = 1'b0;
        imem2.rdata  = '0;

        tv[0] = '{1, 0, 0, 32'h0};
        tv[1] = '{1, 1, 0, 32'h0};
        tv[2] = '{1, 1, 0, 32'h0};
        tv[3] = '{1, 1, 0, 32'h0};
        tv[4] = '{1, 1, 1, 32'h0};
        tv[5] = '{1, 1, 1, 32'h4};
        tv[6] = '{1, 1, 1, 32'h8};
        tv[7] = '{1, 1, 1, 32'hC};

        // reset values
        do_reset();
        chk("rst_req", 32'(imem.req), 0);
        chk("rst_addr", imem.addr, 32'h0);
        chk("rst_valid", 32'(instr_valid), 0);
        chk("rst_instr", instr, 0);
        chk("rst_pc", instr_pc, 0);

        // 2-cycle memory, always waiting: first word 4 cycles after release
        for (int i = 0; i < 8; i++) begin
            if (i > 0)
                tick();
            chk($sformatf("t1_req[%0d]", i), 32'(imem.req), 32'(tv[i].exp_req));
            chk($sformatf("t1_valid[%0d]", i), 32'(instr_valid), 32'(tv[i].exp_valid));
            if (tv[i].exp_valid) begin
                chk($sformatf("t1_pc[%0d]", i), instr_pc, tv[i].exp_pc);
                chk($sformatf("t1_word[%0d]", i), instr, word_of(tv[i].exp_pc));
            end
            apply(tv[i].w, 1'b0, '0);
        end

        // cpu stalled: issue cap then resume
        do_reset();
        issue_cnt = 0;
        repeat (20) step(1'b0);
        chk("cap_issues", issue_cnt, DEPTH);
        chk("cap_req", 32'(imem.req), 0);
        chk("cap_valid", 32'(instr_valid), 1);
        chk("cap_count", 32'(u_dut.u_fifo.count), DEPTH);
        chk("cap_head", instr_pc, 32'h0);
        pops = 0;
        seen_req = 0;
        repeat (12) begin
            step(1'b1);
            if (imem.req)
                seen_req = 1;
        end
        chk("resume_pops", 32'(pops >= 4), 1);
        chk("resume_req", 32'(seen_req), 1);

        // redirect with two fetches in flight
        do_reset();
        repeat (8) step(1'b1);
        do_redir(1'b1, 32'h0000_0102, 2);
        repeat (6) step(1'b1);

        // redirect with rvalid and pop, slower memory, partly filled FIFO
        fixed_lat = 3;
        do_reset();
        apply(1'b0, 1'b0, '0);
        repeat (4) step(1'b0);
        do_redir(1'b1, 32'h2000_0043, -1);
        repeat (6) step(1'b1);
        fixed_lat = 2;

`ifdef IFETCH_STALL_CNT_EN
        // starved cycles counted while no grant is given
        no_gnt = 1;
        do_reset();
        chk("stall_rst", stall_cnt, 0);
        apply(1'b1, 1'b0, '0);
        repeat (6) step(1'b1);
        tick();
        chk("stall_cnt", stall_cnt, 7);
        no_gnt = 0;
`endif

        // random traffic against the stream model
        do_reset();
        rand_gnt = 1;
        rand_lat = 1;
        for (int i = 0; i < 3000; i++) begin
            tick();
            apply($urandom_range(9) < 6, $urandom_range(39) == 0, $urandom);
        end
        rand_gnt = 0;
        pops = 0;
        repeat (30) step(1'b1);
        chk("live_pops", 32'(pops >= 10), 1);

        // asynchronous reset in the middle of traffic
        rand_gnt = 1;
        repeat (7) step(1'b1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req", 32'(imem.req), 0);
        chk("mid_rst_addr", imem.addr, 32'h0);
        chk("mid_rst_valid", 32'(instr_valid), 0);
        chk("mid_rst_instr", instr, 0);
        chk("mid_rst_pc", instr_pc, 0);
        chk("mid_rst_state", 32'(u_dut.state), 32'(S_IDLE));
        do_reset();
        rand_gnt = 0;
        rand_lat = 0;
        pops = 0;
        repeat (12) step(1'b1);
        chk("post_rst_pops", 32'(pops >= 5), 1);

        // fetch address wrap from RESET_PC = FFFF_FFF8
        chk("wrap_n", n2, 3);
        chk("wrap_a0", a2[0], 32'hFFFF_FFF8);
        chk("wrap_a1", a2[1], 32'hFFFF_FFFC);
        chk("wrap_a2", a2[2], 32'h0000_0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
